conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
Streaming 3x3 image-kernel filter. Takes one unsigned pixel per accepted beat in raster order and keeps two internal line buffers, so a single input stream is enough to form the full 3x3 window. Applies a mode-selected kernel (sharpen, gaussian, edge, pass-through) and emits saturated results for interior pixels only. Sits between the pixel source and the frame writer, with valid/ready handshakes on both sides.

Parameters:
PIXEL_WIDTH, 8, bits per unsigned pixel
IMG_W, 64, pixels per line (>=3); sets line-buffer depth
IMG_H, 64, lines per frame (>=3)
ACCW, 16, signed accumulator width; >= PIXEL_WIDTH+5, or >= PIXEL_WIDTH+8 with CONV_CUSTOM_KERNEL_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
in_pixel  in  PIXEL_WIDTH  unsigned input pixel, raster order
mode  in  2  0=sharpen, 1=gaussian, 2=edge, 3=pass-through/custom
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_pixel  out  PIXEL_WIDTH  filtered pixel, clipped to [0, 2^PIXEL_WIDTH-1]
out_last  out  1  marks the last output pixel of a frame
busy  out  1  high from the first accepted pixel of a frame until its out_last handshake

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. On reset: out_valid=0, out_pixel=0, out_last=0, busy=0, col/row counters=0, window registers=0. Line-buffer RAM is not cleared; its contents are don't-care.
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready, so the whole pipeline stalls on backpressure and nothing is dropped.
- Counters: col advances 0..IMG_W-1 on each accept. On wrap, col goes to 0 and row increments. After row IMG_H-1, col IMG_W-1 is accepted, both return to 0 (new frame).
- mode is latched on the first accept of each frame (row=0, col=0) and held for the whole frame. Changes mid-frame have no effect.
- Line buffers: two IMG_W-deep RAMs addressed by col. On each accept, read both RAMs, write lb1[col] <= lb0[col] and lb0[col] <= in_pixel. Window columns shift left once per accept; the new right column is {lb1 out, lb0 out, in_pixel} (top, mid, bottom).
- An output is produced when row>=2 and col>=2 at accept. Its centre is pixel (row-1, col-1). out_valid rises the next cycle: latency 1 cycle from the accepting edge. That gives (IMG_W-2)*(IMG_H-2) outputs per frame.
- out_last is set with the output whose accept had row=IMG_H-1 and col=IMG_W-1.
- Kernel arithmetic: operands are zero-extended to ACCW and summed as signed.
  - sharpen [0 -1 0; -1 5 -1; 0 -1 0]
  - gaussian [1 2 1; 2 4 2; 1 2 1], result >>>4
  - edge [-1 -1 -1; -1 8 -1; -1 -1 -1]
  - pass-through = centre
- Saturation: result <0 gives 0; result >2^PIXEL_WIDTH-1 gives all-ones; otherwise the low PIXEL_WIDTH bits.
- Output hold: out_pixel and out_last stay stable while out_valid && !out_ready. out_valid clears on handshake unless a new result is loaded in the same cycle.
- Simultaneous output handshake and new accept: the new result replaces the old one; out_valid stays 1.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0), and no output appears until two fresh lines have been received.

Optional Feature:
CONV_CUSTOM_KERNEL_EN.
- Defined: adds ports coef in 36 (nine signed 4-bit coefficients, coef[3:0]=top-left, row-major) and coef_shift in 4 (arithmetic right shift applied after the sum). Both are latched with mode at frame start; mode 3 then computes sum(coef_i * pixel_i) >>> coef_shift, then saturates.
- Undefined: those ports are absent and mode 3 is pass-through.

Test Plan:
1. IMG_W=IMG_H=4, constant 100, each mode 0/1/2/3 -> four outputs per frame with values 100/100/0/100; out_last on the 4th output only.
2. Sharpen, centre 255 with neighbours 0 -> 1275 clipped to 255. Edge, centre 0 with neighbours 10 -> -80 clipped to 0.
3. Gaussian on ramp in_pixel=col*16 (IMG_W=8) -> each output equals its centre pixel (col-1)*16, within exact >>>4 rounding. Output count (8-2)*(IMG_H-2).
4. out_ready held low 5 cycles mid-frame -> in_ready low, out_pixel stable, no lost or duplicated outputs versus the golden model; the full-throughput case gives one output per cycle.
5. mode toggled 0->2 mid-frame -> the whole frame uses sharpen; the next frame uses edge.
6. rst_n pulsed after 1.5 rows -> out_valid=0 immediately; a following clean frame matches the golden model, with the first output after 2*IMG_W+3 accepts. With the macro defined: identity kernel (centre coef 1, shift 0) in mode 3 -> output equals input centre.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// rtl/conv3x3_stream_if.sv - pixel-in / pixel-out handshake bundle for conv3x3_stream (CONV_CUSTOM_KERNEL_EN adds coef ports)
interface conv3x3_stream_if #(
  parameter int PIXEL_WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [PIXEL_WIDTH-1:0] in_pixel;
  logic [1:0]             mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [PIXEL_WIDTH-1:0] out_pixel;
  logic                   out_last;
  logic                   busy;
`ifdef CONV_CUSTOM_KERNEL_EN
  logic [35:0]            coef;
  logic [3:0]             coef_shift;
`endif

  // filter side: consumes the pixel stream, produces the filtered stream
  modport slave (
    input  in_valid, in_pixel, mode, out_ready,
`ifdef CONV_CUSTOM_KERNEL_EN
    input  coef, coef_shift,
`endif
    output in_ready, out_valid, out_pixel, out_last, busy
  );

  // source/sink side: pixel producer and frame writer
  modport master (
    output in_valid, in_pixel, mode, out_ready,
`ifdef CONV_CUSTOM_KERNEL_EN
    output coef, coef_shift,
`endif
    input  in_ready, out_valid, out_pixel, out_last, busy
  );

endinterface

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 kernel filter with two line buffers; CONV_CUSTOM_KERNEL_EN enables a programmable mode-3 kernel
module conv3x3_stream #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int ACCW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  conv3x3_stream_if.slave s_if
);

  localparam int COLW = $clog2(IMG_W);
  localparam int ROWW = $clog2(IMG_H);
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_W - 1);
  localparam logic [COLW-1:0] COL_TWO  = COLW'(2);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_H - 1);
  localparam logic [ROWW-1:0] ROW_TWO  = ROWW'(2);

  // raster position of the next pixel to be accepted
  logic [COLW-1:0]        r_col;
  logic [ROWW-1:0]        r_row;
  logic [1:0]             r_mode;
`ifdef CONV_CUSTOM_KERNEL_EN
  logic [35:0]            r_coef;
  logic [3:0]             r_coef_shift;
  logic signed [ACCW-1:0] w_cust_sum;
  logic signed [ACCW-1:0] w_cust;
`endif

  // lb0 holds the previous line, lb1 the line before it
  logic [PIXEL_WIDTH-1:0] r_lb0 [IMG_W];
  logic [PIXEL_WIDTH-1:0] r_lb1 [IMG_W];

  // two most recent window columns (top, mid, bottom); the third comes live from the RAMs
  logic [PIXEL_WIDTH-1:0] r_wc0 [3];
  logic [PIXEL_WIDTH-1:0] r_wc1 [3];

  logic                   r_out_valid;
  logic [PIXEL_WIDTH-1:0] r_out_pixel;
  logic                   r_out_last;
  logic                   r_busy;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_emit;
  logic                   w_last_pix;
  logic [PIXEL_WIDTH-1:0] w_new [3];
  logic [PIXEL_WIDTH-1:0] w_win [9];
  logic signed [ACCW-1:0] w_p [9];
  logic signed [ACCW-1:0] w_sharp;
  logic signed [ACCW-1:0] w_gauss;
  logic signed [ACCW-1:0] w_edge;
  logic signed [ACCW-1:0] w_res;
  logic [PIXEL_WIDTH-1:0] w_sat;

  // any backpressure on the output stalls the whole pipeline
  assign w_in_ready = !r_out_valid || s_if.out_ready;
  assign w_accept   = s_if.in_valid && w_in_ready;
  assign w_first    = (r_col == '0) && (r_row == '0);
  assign w_emit     = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // assemble the 3x3 window seen by the current accept (row-major, index 4 is the centre)
  always_comb begin
    w_new[0] = r_lb1[r_col];
    w_new[1] = r_lb0[r_col];
    w_new[2] = s_if.in_pixel;
    for (int rr = 0; rr < 3; rr++) begin
      w_win[rr*3 + 0] = r_wc0[rr];
      w_win[rr*3 + 1] = r_wc1[rr];
      w_win[rr*3 + 2] = w_new[rr];
    end
    for (int k = 0; k < 9; k++) begin
      w_p[k] = $signed({{(ACCW-PIXEL_WIDTH){1'b0}}, w_win[k]});
    end
  end

  // fixed kernels, written as shift-and-add so no multipliers are needed
  always_comb begin
    w_sharp = (w_p[4] <<< 2) + w_p[4] - w_p[1] - w_p[3] - w_p[5] - w_p[7];
    w_gauss = ((w_p[0] + w_p[2] + w_p[6] + w_p[8])
              + ((w_p[1] + w_p[3] + w_p[5] + w_p[7]) <<< 1)
              + (w_p[4] <<< 2)) >>> 4;
    w_edge  = (w_p[4] <<< 3)
              - (w_p[0] + w_p[1] + w_p[2] + w_p[3] + w_p[5] + w_p[6] + w_p[7] + w_p[8]);
  end

`ifdef CONV_CUSTOM_KERNEL_EN
  // programmable kernel: signed 4-bit coefficients, top-left in the low nibble
  always_comb begin
    w_cust_sum = '0;
    for (int k = 0; k < 9; k++) begin
      w_cust_sum = w_cust_sum
                 + ($signed({{(ACCW-4){r_coef[k*4 + 3]}}, r_coef[k*4 +: 4]}) * w_p[k]);
    end
    w_cust = w_cust_sum >>> r_coef_shift;
  end
`endif

  // select the kernel chosen at frame start, then clip into the pixel range
  always_comb begin
    case (r_mode)
      2'd0:    w_res = w_sharp;
      2'd1:    w_res = w_gauss;
      2'd2:    w_res = w_edge;
`ifdef CONV_CUSTOM_KERNEL_EN
      default: w_res = w_cust;
`else
      default: w_res = w_p[4];
`endif
    endcase
    if (w_res[ACCW-1]) begin
      w_sat = '0;
    end else if (|w_res[ACCW-2:PIXEL_WIDTH]) begin
      w_sat = '1;
    end else begin
      w_sat = w_res[PIXEL_WIDTH-1:0];
    end
  end

  // position counters, frame-start latch of the kernel selection and window column shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= '0;
`ifdef CONV_CUSTOM_KERNEL_EN
      r_coef       <= '0;
      r_coef_shift <= '0;
`endif
      for (int rr = 0; rr < 3; rr++) begin
        r_wc0[rr] <= '0;
        r_wc1[rr] <= '0;
      end
    end else if (w_accept) begin
      if (w_first) begin
        r_mode <= s_if.mode;
`ifdef CONV_CUSTOM_KERNEL_EN
        r_coef       <= s_if.coef;
        r_coef_shift <= s_if.coef_shift;
`endif
      end
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      for (int rr = 0; rr < 3; rr++) begin
        r_wc0[rr] <= r_wc1[rr];
        r_wc1[rr] <= w_new[rr];
      end
    end
  end

  // line buffers move each column down one line per accept; contents are never cleared
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= s_if.in_pixel;
    end
  end

  // output register: a fresh result overrides, otherwise valid drops once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_pixel <= w_sat;
      r_out_last  <= w_last_pix;
    end else if (s_if.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // busy spans first accepted pixel of a frame through the handshake of its last output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
    end else if (r_out_valid && s_if.out_ready && r_out_last) begin
      r_busy <= 1'b0;
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_pixel = r_out_pixel;
  assign s_if.out_last  = r_out_last;
  assign s_if.busy      = r_busy;

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - randomized self-checking bench for conv3x3_stream against an image-level model
module tb_conv3x3_stream;

  localparam int PW   = 8;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int ACCW = 16;
  localparam int NOUT = (W-2)*(H-2);
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv3x3_stream_if #(.PIXEL_WIDTH(PW)) bus ();

  conv3x3_stream #(.PIXEL_WIDTH(PW), .IMG_W(W), .IMG_H(H), .ACCW(ACCW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_if (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int K_TAB [4][9] = '{'{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
                       '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
                       '{-1, -1, -1, -1, 8, -1, -1, -1, -1},
                       '{ 0,  0,  0,  0, 1,  0,  0,  0,  0}};
  int EXP_CONST [4] = '{100, 100, 0, 100};

  // image-level model state
  int          img [H][W];
  int          m_row = 0, m_col = 0, m_mode = 0;
  logic [35:0] m_coef = 36'h0_0001_0000;
  int          m_shift = 0;
  typedef struct { int pix; int last; } exp_t;
  exp_t        exp_q [$];
  exp_t        e;
  int          obs_q [$];
  int          hs_cyc [$];
  int          last_idx = -1;
  int          n_last = 0;
  int          cyc = 0;
  bit          prev_stall = 0;
  int          prev_pix = 0, prev_last = 0;
  bit          lat_pend = 0;
  int          acc_since_rst = 0;
  int          first_out_acc = -1;

  int          hold_req_n = 0;
  int          hold_seen = 0;
  int          hold_cnt = 0;
  bit          rdy_rand = 0;

  function automatic int kern(input int md, input int w[9]);
    int s;
    int cf;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      cf = K_TAB[md][k];
`ifdef CONV_CUSTOM_KERNEL_EN
      if (md == 3) cf = int'($signed(m_coef[k*4 +: 4]));
`endif
      s += cf * w[k];
    end
    if (md == 1) s = s / 16;
`ifdef CONV_CUSTOM_KERNEL_EN
    if (md == 3) s = s >>> m_shift;
`endif
    if (s < 0) return 0;
    if (s > PMAX) return PMAX;
    return s;
  endfunction

  function automatic int model_at(input int r, input int c, input int md);
    int win[9];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win[i*3 + j] = img[r-1+i][c-1+j];
    return kern(md, win);
  endfunction

  function automatic int pixval(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return c * 16;
      3:       return (r == 2 && c == 2) ? 255 : 0;
      4:       return (r == 2 && c == 2) ? 0 : 10;
      default: return int'($urandom_range(0, PMAX));
    endcase
  endfunction

  // compare process: checks every output handshake, hold, latency and ready rule
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_row = 0; m_col = 0;
      exp_q.delete();
      prev_stall = 0; lat_pend = 0;
      acc_since_rst = 0; first_out_acc = -1;
    end else begin
      chk("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready));
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_pixel", bus.out_pixel, prev_pix);
        chk("hold_last", bus.out_last, prev_last);
      end
      if (lat_pend) chk("latency", bus.out_valid, 1);
      if (bus.out_valid && first_out_acc < 0) first_out_acc = acc_since_rst;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra_output: got pixel %0d expected no output", bus.out_pixel);
        end else begin
          e = exp_q.pop_front();
          chk("out_pixel", bus.out_pixel, e.pix);
          chk("out_last", bus.out_last, e.last);
        end
        obs_q.push_back(int'(bus.out_pixel));
        hs_cyc.push_back(cyc);
        if (bus.out_last) begin
          last_idx = obs_q.size() - 1;
          n_last++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pixel;
      prev_last  = bus.out_last;
      lat_pend   = 0;
      if (bus.in_valid && bus.in_ready) begin
        if (m_row == 0 && m_col == 0) begin
          m_mode = bus.mode;
`ifdef CONV_CUSTOM_KERNEL_EN
          m_coef  = bus.coef;
          m_shift = bus.coef_shift;
`endif
        end
        img[m_row][m_col] = bus.in_pixel;
        if (m_row >= 2 && m_col >= 2) begin
          e.pix  = model_at(m_row-1, m_col-1, m_mode);
          e.last = (m_row == H-1 && m_col == W-1) ? 1 : 0;
          exp_q.push_back(e);
          lat_pend = 1;
        end
        acc_since_rst++;
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row++;
          if (m_row == H) m_row = 0;
        end
      end
    end
  end

  // downstream ready: steady, random, or a requested 5-cycle hold
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_seen != hold_req_n) begin
        hold_seen = hold_req_n;
        hold_cnt = 5;
      end
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        hold_cnt--;
      end else if (rdy_rand) begin
        bus.out_ready = ($urandom_range(0, 99) < 70);
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic send_frame(input int md, input int kind, input int npix, input int gaps,
                            input int sw_at, input int sw_mode, input int hold_at);
    int t;
    for (int i = 0; i < npix; i++) begin
      if (i == 1) chk("busy_mid", bus.busy, 1);
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_pixel = PW'(pixval(kind, i / W, i % W));
      if (i == 0) bus.mode = 2'(md);
      if (i == sw_at) bus.mode = 2'(sw_mode);
      if (i == hold_at) hold_req_n++;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: pixel %0d not accepted within %0d cycles", i, t);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", (t < 1000) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic frame_end_checks(input int base, input int nl0);
    chk("frame_out_count", obs_q.size() - base, NOUT);
    chk("frame_last_idx", last_idx, base + NOUT - 1);
    chk("frame_last_count", n_last - nl0, 1);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int nl0;
    int win[9];
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.mode     = 2'd0;
`ifdef CONV_CUSTOM_KERNEL_EN
    bus.coef       = 36'h0_0001_0000;
    bus.coef_shift = 4'd0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pixel", bus.out_pixel, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // pin the model with hand-computed kernels
    for (int k = 0; k < 9; k++) win[k] = 100;
    for (int m = 0; m < 4; m++) chk("pin_const", kern(m, win), EXP_CONST[m]);
    for (int k = 0; k < 9; k++) win[k] = 0;
    win[4] = 255;
    chk("pin_sharpen_clip", kern(0, win), 255);
    for (int k = 0; k < 9; k++) win[k] = 10;
    win[4] = 0;
    chk("pin_edge_clip", kern(2, win), 0);

    // constant frames in every mode
    for (int m = 0; m < 4; m++) begin
      base = obs_q.size(); nl0 = n_last;
      send_frame(m, 0, W*H, 0, -1, 0, -1);
      drain();
      frame_end_checks(base, nl0);
      chk("const_value", obs_q[base + 5], EXP_CONST[m]);
    end

    // sharpen impulse clips high; edge with dark centre clips low
    base = obs_q.size(); nl0 = n_last;
    send_frame(0, 3, W*H, 0, -1, 0, -1);
    drain();
    frame_end_checks(base, nl0);
    chk("sharpen_peak", obs_q[base + 7], 255);
    chk("sharpen_corner", obs_q[base + 0], 0);
    base = obs_q.size(); nl0 = n_last;
    send_frame(2, 4, W*H, 0, -1, 0, -1);
    drain();
    frame_end_checks(base, nl0);
    chk("edge_hole", obs_q[base + 7], 0);
    chk("edge_near", obs_q[base + 0], 10);

    // gaussian on a ramp reproduces the ramp; full throughput gives back-to-back outputs
    base = obs_q.size(); nl0 = n_last;
    send_frame(1, 1, W*H, 0, -1, 0, -1);
    drain();
    frame_end_checks(base, nl0);
    for (int k = 0; k < NOUT; k++) chk("gauss_ramp", obs_q[base + k], (k % (W-2) + 1) * 16);
    for (int k = 0; k < NOUT - 1; k++)
      if (k % (W-2) != W-3) chk("throughput", hs_cyc[base + k + 1] - hs_cyc[base + k], 1);

    // 5-cycle backpressure mid-frame
    base = obs_q.size(); nl0 = n_last;
    send_frame(0, 2, W*H, 0, -1, 0, 30);
    drain();
    frame_end_checks(base, nl0);

    // random data, random gaps, random downstream readiness
    rdy_rand = 1;
    for (int f = 0; f < 8; f++) begin
      base = obs_q.size(); nl0 = n_last;
      send_frame(f % 4, 2, W*H, 1, -1, 0, -1);
      drain();
      frame_end_checks(base, nl0);
    end
    rdy_rand = 0;

    // mode change mid-frame only takes effect on the next frame
    base = obs_q.size(); nl0 = n_last;
    send_frame(0, 2, W*H, 0, 20, 2, -1);
    drain();
    frame_end_checks(base, nl0);
    chk("toggle_sharpen", obs_q[base], model_at(1, 1, 0));
    base = obs_q.size(); nl0 = n_last;
    send_frame(2, 2, W*H, 0, -1, 0, -1);
    drain();
    frame_end_checks(base, nl0);
    chk("toggle_edge", obs_q[base], model_at(1, 1, 2));

    // reset after 1.5 lines, then after 2.5 lines with an output pending
    send_frame(0, 2, W + W/2, 0, -1, 0, -1);
    #2 rst_n = 1'b0;
    #1 chk("rst15_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 2, 2*W + 4, 0, -1, 0, -1);
    chk("pre_reset_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    base = obs_q.size(); nl0 = n_last;
    send_frame(3, 2, W*H, 0, -1, 0, -1);
    drain();
    frame_end_checks(base, nl0);
    chk("first_out_accepts", first_out_acc, 2*W + 3);
    for (int k = 0; k < NOUT; k++)
      chk("mode3_centre", obs_q[base + k], img[k / (W-2) + 1][k % (W-2) + 1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
